// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request/response responder: the 3-bit
// function codes and the responder's FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MUL  = 3'b011;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

endpackage

// File: rtl/alu_seq_responder_if.sv
// Request/response bundle between an ALU initiator (master) and the
// sequential ALU responder (slave). Both channels use valid/ready.
interface alu_seq_responder_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_f;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zero;
  logic             busy;

  modport master (
    output req_valid, req_f, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zero, busy
  );

  modport slave (
    input  req_valid, req_f, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zero, busy
  );

endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// One partial product is added per cycle while run is high; done is raised
// combinationally on the last iteration, with result already including it.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign done   = run && (cnt == CW'(WIDTH - 1));
  assign result = acc_next;

  // Capture operands on start, then advance one multiplier bit per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (run) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_next;
      cnt    <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked ALU responder: single-cycle logic ops, add/sub/slt, and an
// iterative multiply. Results sit in an output register until consumed;
// a new request may be accepted in the same cycle the old result drains.
module alu_seq_responder
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_seq_responder_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             start_mul;
  logic             load_rsp;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic             mul_done;
  logic [WIDTH-1:0] mul_result;
  logic [WIDTH-1:0] rsp_y_q;
  logic             rsp_zero_q;

  // Single-cycle function select; subtract is shared with signed compare.
  always_comb begin
    diff  = bus.req_a + ~bus.req_b + 1'b1;
    slt   = (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]) ? bus.req_a[WIDTH-1]
                                                       : diff[WIDTH-1];
    alu_y = '0;
    case (bus.req_f)
      ALU_AND:  alu_y = bus.req_a & bus.req_b;
      ALU_OR:   alu_y = bus.req_a | bus.req_b;
      ALU_ADD:  alu_y = bus.req_a + bus.req_b;
      ALU_ANDN: alu_y = bus.req_a & ~bus.req_b;
      ALU_ORN:  alu_y = bus.req_a | ~bus.req_b;
      ALU_SUB:  alu_y = diff;
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}}, slt};
      default:  alu_y = '0;
    endcase
  end

  assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign accept        = bus.req_valid && bus.req_ready;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_mul),
    .run    (state == MUL),
    .a      (bus.req_a),
    .b      (bus.req_b),
    .done   (mul_done),
    .result (mul_result)
  );

  // Next-state and result-load decisions; RESP with a drain and a new
  // request behaves exactly like an accept from IDLE.
  always_comb begin
    state_next = state;
    start_mul  = 1'b0;
    load_rsp   = 1'b0;
    load_val   = alu_y;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (bus.req_f == ALU_MUL) begin
            start_mul  = 1'b1;
            state_next = MUL;
          end else begin
            load_rsp   = 1'b1;
            state_next = RESP;
          end
        end else if (state == RESP && bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      MUL: begin
        if (mul_done) begin
          load_rsp   = 1'b1;
          load_val   = mul_result;
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Output register: result and its zero flag are captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_y_q    <= '0;
      rsp_zero_q <= 1'b0;
    end else if (load_rsp) begin
      rsp_y_q    <= load_val;
      rsp_zero_q <= (load_val == '0);
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_y     = rsp_y_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.busy      = (state == MUL);

endmodule
